// File: rtl/data_sram_bridge_if.sv
// Split address/data handshake bus between the data-SRAM bridge and a
// variable-latency data memory. The bridge is the master; the memory is
// the slave. The request fields are held stable while mem_req is high.
interface data_sram_bridge_if;
    logic        mem_req;
    logic        mem_wr;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_addr_ok;
    logic        mem_data_ok;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_wr,
        output mem_size,
        output mem_addr,
        output mem_wstrb,
        output mem_wdata,
        input  mem_addr_ok,
        input  mem_data_ok,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_wr,
        input  mem_size,
        input  mem_addr,
        input  mem_wstrb,
        input  mem_wdata,
        output mem_addr_ok,
        output mem_data_ok,
        output mem_rdata
    );
endinterface

// File: rtl/data_sram_bridge.sv
// Data-SRAM bridge: turns the memory-stage single-cycle request of the CPU
// core into a split address/data handshake, stalls the pipeline until the
// access finishes and presents the result for exactly one cycle. A watchdog
// forces completion (with an error flag) of accesses whose data never arrive.
module data_sram_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned TCNT_W         = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cpu_en,
    input  logic [3:0]                cpu_wen,
    input  logic [31:0]               cpu_addr,
    input  logic [31:0]               cpu_wdata,
    output logic [31:0]               cpu_rdata,
    output logic                      cpu_done,
    output logic                      cpu_stall,
    output logic                      cpu_err,
    data_sram_bridge_if.master        mem
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [TCNT_W-1:0] TIMEOUT_V = TCNT_W'(TIMEOUT_CYCLES);
    localparam bit                WDOG_ON   = (TIMEOUT_CYCLES != 0);

    state_t             state_reg;
    logic [31:0]        addr_reg;
    logic [31:0]        wdata_reg;
    logic [3:0]         wen_reg;
    logic [1:0]         size_reg;
    logic               req_reg;
    logic               done_reg;
    logic               err_reg;
    logic [31:0]        data_reg;
    logic [TCNT_W-1:0]  wdog_reg;
    // Set once the core has abandoned an access that the memory already
    // accepted; the result is then dropped even if cpu_en comes back.
    logic               flush_reg;

    logic               is_write;
    logic [TCNT_W-1:0]  wdog_inc;
    logic               timeout_hit;
    logic               live;

    // Transfer size implied by the byte strobes; reads are always full words.
    function automatic logic [1:0] size_of(input logic [3:0] wen);
        logic [1:0] sz;
        case (wen)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: sz = 2'd0;
            4'b0011, 4'b1100:                   sz = 2'd1;
            default:                            sz = 2'd2;
        endcase
        return sz;
    endfunction

    assign is_write = |wen_reg;

    // Watchdog increments but sticks at all-ones so it can never wrap back
    // through the timeout value.
    assign wdog_inc    = (&wdog_reg) ? wdog_reg : wdog_reg + 1'b1;
    assign timeout_hit = WDOG_ON && (wdog_inc == TIMEOUT_V);

    // Control FSM with registered request/response outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
            addr_reg  <= '0;
            wdata_reg <= '0;
            wen_reg   <= '0;
            size_reg  <= '0;
            req_reg   <= 1'b0;
            done_reg  <= 1'b0;
            err_reg   <= 1'b0;
            data_reg  <= '0;
            wdog_reg  <= '0;
            flush_reg <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    done_reg <= 1'b0;
                    err_reg  <= 1'b0;
                    data_reg <= '0;
                    // Stale mem_data_ok here belongs to no request and is ignored.
                    if (cpu_en) begin
                        addr_reg  <= cpu_addr;
                        wdata_reg <= cpu_wdata;
                        wen_reg   <= cpu_wen;
                        size_reg  <= size_of(cpu_wen);
                        flush_reg <= 1'b0;
                        req_reg   <= 1'b1;
                        state_reg <= S_REQ;
                    end
                end

                S_REQ: begin
                    if (mem.mem_addr_ok) begin
                        req_reg <= 1'b0;
                        if (mem.mem_data_ok) begin
                            // Zero-wait memory: the whole access ends here.
                            if (cpu_en) begin
                                state_reg <= S_DONE;
                                done_reg  <= 1'b1;
                                err_reg   <= 1'b0;
                                data_reg  <= is_write ? '0 : mem.mem_rdata;
                            end else begin
                                state_reg <= S_IDLE;
                            end
                        end else begin
                            state_reg <= S_WAIT;
                            wdog_reg  <= '0;
                            flush_reg <= ~cpu_en;
                        end
                    end else if (!cpu_en) begin
                        // Flushed before the memory saw it: nothing to undo.
                        req_reg   <= 1'b0;
                        state_reg <= S_IDLE;
                    end
                end

                S_WAIT: begin
                    if (mem.mem_data_ok || timeout_hit) begin
                        if (cpu_en && !flush_reg) begin
                            state_reg <= S_DONE;
                            done_reg  <= 1'b1;
                            err_reg   <= ~mem.mem_data_ok;
                            data_reg  <= (mem.mem_data_ok && !is_write) ? mem.mem_rdata : '0;
                        end else begin
                            // Accepted access completes silently; result discarded.
                            state_reg <= S_IDLE;
                        end
                        flush_reg <= 1'b0;
                        wdog_reg  <= wdog_inc;
                    end else begin
                        wdog_reg  <= wdog_inc;
                        flush_reg <= flush_reg | ~cpu_en;
                    end
                end

                S_DONE: begin
                    // Result is shown for exactly one cycle.
                    done_reg  <= 1'b0;
                    err_reg   <= 1'b0;
                    data_reg  <= '0;
                    state_reg <= S_IDLE;
                end

                default: begin
                    state_reg <= S_IDLE;
                    req_reg   <= 1'b0;
                    done_reg  <= 1'b0;
                    err_reg   <= 1'b0;
                end
            endcase
        end
    end

    // Reset overrides every output, including the combinational stall.
    assign live = ~rst;

    assign cpu_stall = live & cpu_en & (state_reg != S_DONE);
    assign cpu_done  = live & done_reg;
    assign cpu_err   = live & err_reg;
    assign cpu_rdata = live ? data_reg : '0;

    assign mem.mem_req   = live & req_reg;
    assign mem.mem_wr    = live & is_write;
    assign mem.mem_size  = live ? size_reg  : 2'd0;
    assign mem.mem_addr  = live ? addr_reg  : '0;
    assign mem.mem_wstrb = live ? wen_reg   : 4'd0;
    assign mem.mem_wdata = live ? wdata_reg : '0;

endmodule

// File: tb/tb_data_sram_bridge.sv
// Self-checking bench for data_sram_bridge (watchdog set to 4 cycles):
// directed scenarios followed by randomized accesses predicted from the
// access-latency rules.
module tb_data_sram_bridge;

    localparam int T = 4;

    logic        clk;
    logic        rst;
    logic        cpu_en;
    logic [3:0]  cpu_wen;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_done;
    logic        cpu_stall;
    logic        cpu_err;

    data_sram_bridge_if mem_if ();

    data_sram_bridge #(
        .TIMEOUT_CYCLES (T),
        .TCNT_W         (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_en    (cpu_en),
        .cpu_wen   (cpu_wen),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_done  (cpu_done),
        .cpu_stall (cpu_stall),
        .cpu_err   (cpu_err),
        .mem       (mem_if)
    );

    int checks = 0;
    int errors = 0;
    int txn    = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Size from the number of enabled byte lanes (read counts as a word).
    function automatic logic [1:0] exp_size(input logic [3:0] w);
        int n;
        n = $countones(w);
        if (n == 1) return 2'd0;
        if (n == 2) return 2'd1;
        return 2'd2;
    endfunction

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_stall"}, 32'(cpu_stall), 32'd0);
        chk({tag, "_done"},  32'(cpu_done),  32'd0);
        chk({tag, "_err"},   32'(cpu_err),   32'd0);
        chk({tag, "_rdata"}, cpu_rdata,      32'd0);
        chk({tag, "_req"},   32'(mem_if.mem_req),   32'd0);
        chk({tag, "_addr"},  mem_if.mem_addr,       32'd0);
        chk({tag, "_wstrb"}, 32'(mem_if.mem_wstrb), 32'd0);
        chk({tag, "_size"},  32'(mem_if.mem_size),  32'd0);
    endtask

    // One complete access. The memory accepts after a REQ cycles without
    // addr_ok; data_ok arrives k cycles after acceptance (k=0: same cycle as
    // addr_ok, k>T: never). Called in IDLE, returns at start of the cycle
    // after cpu_done with cpu_en still high.
    task automatic do_access(input logic [3:0] wen, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [31:0] rd,
                             input int a, input int k);
        int          d;
        int          tw;
        logic        e_err;
        logic [31:0] e_rd;
        e_err = (k > T);
        tw    = (k == 0) ? 0 : ((k < T) ? k : T);
        d     = a + 2 + tw;
        e_rd  = (e_err || wen != 4'd0) ? 32'd0 : rd;
        cpu_en    = 1'b1;
        cpu_wen   = wen;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        for (int c = 0; c <= d; c++) begin
            if (c > 0) begin
                // The bridge must work from its own latched copy.
                cpu_addr  = $urandom;
                cpu_wdata = $urandom;
                cpu_wen   = 4'($urandom);
            end
            mem_if.mem_addr_ok = (c == a + 1);
            mem_if.mem_data_ok = (k == 0) ? (c == a + 1) : (!e_err && (c == a + 1 + k));
            mem_if.mem_rdata   = mem_if.mem_data_ok ? rd : ~rd;
            @(negedge clk);
            chk("stall", 32'(cpu_stall), 32'(c < d));
            chk("req",   32'(mem_if.mem_req), 32'(c >= 1 && c <= a + 1));
            chk("done",  32'(cpu_done), 32'(c == d));
            if (c >= 1 && c <= a + 1) begin
                chk("mem_wr",    32'(mem_if.mem_wr),    32'(wen != 4'd0));
                chk("mem_size",  32'(mem_if.mem_size),  32'(exp_size(wen)));
                chk("mem_addr",  mem_if.mem_addr,       addr);
                chk("mem_wstrb", 32'(mem_if.mem_wstrb), 32'(wen));
                chk("mem_wdata", mem_if.mem_wdata,      wdata);
            end
            if (c == d) begin
                chk("rdata", cpu_rdata, e_rd);
                chk("err",   32'(cpu_err), 32'(e_err));
            end
            step();
        end
        mem_if.mem_addr_ok = 1'b0;
        mem_if.mem_data_ok = 1'b0;
        txn++;
        $display("txn %0d wen=%b addr=%h a=%0d k=%0d latency=%0d err=%0b rdata=%h",
                 txn, wen, addr, a, k, d, e_err, e_rd);
    endtask

    logic [3:0] picks [8] = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF};

    initial begin
        rst = 1'b1;
        cpu_en = 1'b1;
        cpu_wen = 4'd0;
        cpu_addr = 32'h1234_5678;
        cpu_wdata = 32'd0;
        mem_if.mem_addr_ok = 1'b0;
        mem_if.mem_data_ok = 1'b0;
        mem_if.mem_rdata   = 32'd0;

        // Reset: outputs zero even with cpu_en high.
        step();
        step();
        @(negedge clk);
        chk_idle_outputs("reset");
        step();
        rst = 1'b0;
        cpu_en = 1'b0;
        mem_if.mem_data_ok = 1'b1;
        mem_if.mem_rdata = 32'h5555_AAAA;
        @(negedge clk);
        step();
        mem_if.mem_data_ok = 1'b0;
        @(negedge clk);
        chk("stale_done", 32'(cpu_done), 32'd0);
        chk("stale_req",  32'(mem_if.mem_req), 32'd0);
        $display("txn reset + stale data_ok in IDLE");
        step();

        // Word read, zero-wait memory.
        do_access(4'b0000, 32'h0000_0100, 32'd0, 32'hDEAD_BEEF, 0, 0);
        cpu_en = 1'b0;
        step();

        // Byte write, addr_ok after 3 cycles, data_ok 2 later.
        do_access(4'b0100, 32'h0000_0202, 32'h00AB_0000, 32'h1234_5678, 3, 2);
        cpu_en = 1'b0;
        step();

        // Flush before accept.
        cpu_en = 1'b1; cpu_wen = 4'd0; cpu_addr = 32'h300;
        @(negedge clk);
        chk("fb_stall0", 32'(cpu_stall), 32'd1);
        step();
        @(negedge clk);
        chk("fb_req1", 32'(mem_if.mem_req), 32'd1);
        step();
        cpu_en = 1'b0;
        @(negedge clk);
        chk("fb_req2", 32'(mem_if.mem_req), 32'd1);
        chk("fb_stall2", 32'(cpu_stall), 32'd0);
        step();
        mem_if.mem_data_ok = 1'b1;
        mem_if.mem_rdata = 32'h7777_7777;
        @(negedge clk);
        chk("fb_req3", 32'(mem_if.mem_req), 32'd0);
        chk("fb_done3", 32'(cpu_done), 32'd0);
        step();
        mem_if.mem_data_ok = 1'b0;
        @(negedge clk);
        chk("fb_done4", 32'(cpu_done), 32'd0);
        chk("fb_req4", 32'(mem_if.mem_req), 32'd0);
        $display("txn flush before accept");
        step();

        // Flush after accept, then a normal read.
        cpu_en = 1'b1; cpu_wen = 4'd0; cpu_addr = 32'h400;
        step();
        mem_if.mem_addr_ok = 1'b1;
        @(negedge clk);
        chk("fa_req1", 32'(mem_if.mem_req), 32'd1);
        step();
        mem_if.mem_addr_ok = 1'b0;
        cpu_en = 1'b0;
        @(negedge clk);
        chk("fa_req2", 32'(mem_if.mem_req), 32'd0);
        chk("fa_stall2", 32'(cpu_stall), 32'd0);
        step();
        mem_if.mem_data_ok = 1'b1;
        mem_if.mem_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        chk("fa_done3", 32'(cpu_done), 32'd0);
        step();
        mem_if.mem_data_ok = 1'b0;
        @(negedge clk);
        chk("fa_done4", 32'(cpu_done), 32'd0);
        chk("fa_rdata4", cpu_rdata, 32'd0);
        $display("txn flush after accept");
        step();
        do_access(4'b0000, 32'h0000_0404, 32'd0, 32'h0BAD_F00D, 1, 1);
        cpu_en = 1'b0;
        step();

        // Watchdog timeout, then error clears.
        do_access(4'b0000, 32'h0000_0500, 32'd0, 32'h1111_2222, 0, 99);
        cpu_en = 1'b0;
        @(negedge clk);
        chk("to_err_clear", 32'(cpu_err), 32'd0);
        chk("to_done_clear", 32'(cpu_done), 32'd0);
        step();

        // Reset in the middle of WAIT.
        cpu_en = 1'b1; cpu_wen = 4'b1111; cpu_addr = 32'h600; cpu_wdata = 32'h89AB_CDEF;
        step();
        mem_if.mem_addr_ok = 1'b1;
        step();
        mem_if.mem_addr_ok = 1'b0;
        @(negedge clk);
        chk("rw_stall", 32'(cpu_stall), 32'd1);
        chk("rw_req", 32'(mem_if.mem_req), 32'd0);
        step();
        rst = 1'b1;
        @(negedge clk);
        chk("rw_stall_in_rst", 32'(cpu_stall), 32'd0);
        step();
        rst = 1'b0;
        cpu_en = 1'b0;
        @(negedge clk);
        chk_idle_outputs("rw_after");
        chk("rw_wr", 32'(mem_if.mem_wr), 32'd0);
        step();
        mem_if.mem_data_ok = 1'b1;
        @(negedge clk);
        step();
        mem_if.mem_data_ok = 1'b0;
        @(negedge clk);
        chk("rw_no_done", 32'(cpu_done), 32'd0);
        $display("txn reset mid-WAIT");
        step();

        // Back-to-back accesses with no idle gap on cpu_en.
        do_access(4'b0011, 32'h0000_0700, 32'h0000_BEEF, 32'hAAAA_0000, 0, 0);
        do_access(4'b0000, 32'h0000_0704, 32'd0, 32'h1357_9BDF, 1, 3);
        cpu_en = 1'b0;
        step();

        // Randomized accesses with random idle gaps and stale data_ok pulses.
        for (int i = 0; i < 40; i++) begin
            int r;
            int k;
            int gap;
            r = $urandom_range(0, 9);
            k = (r == 9) ? 99 : (r % 5);
            do_access(picks[$urandom_range(0, 7)], $urandom, $urandom, $urandom,
                      $urandom_range(0, 3), k);
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                cpu_en = 1'b0;
                mem_if.mem_data_ok = 1'($urandom_range(0, 1));
                @(negedge clk);
                chk("gap_done", 32'(cpu_done), 32'd0);
                chk("gap_req", 32'(mem_if.mem_req), 32'd0);
                step();
            end
            mem_if.mem_data_ok = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_sram_bridge.md
Name: data_sram_bridge

Overview:
- Sits directly downstream of the CPU core's data-memory port (memory stage).
- Converts the core's single-cycle request (enable, byte-write strobes, address, write data) into a split address/data handshake toward a variable-latency data memory.
- Holds the pipeline with a stall signal until the access completes, then presents the read data for exactly one cycle.
- Includes a watchdog that terminates hung accesses with an error flag.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles spent in WAIT before forced completion; 0 disables the watchdog.
- TCNT_W, 8: width of the watchdog counter; must satisfy 2^TCNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- cpu_en  in  1  core memory-stage access enable.
- cpu_wen  in  4  byte write strobes; 0000 means read.
- cpu_addr  in  32  byte address (ALU output, memory stage).
- cpu_wdata  in  32  byte-lane-aligned write data.
- cpu_rdata  out  32  read data, valid when cpu_done=1.
- cpu_done  out  1  access complete this cycle.
- cpu_stall  out  1  hold the memory stage and all earlier stages.
- cpu_err  out  1  completed access timed out (valid with cpu_done).
- mem_req  out  1  request valid.
- mem_wr  out  1  1=write, 0=read.
- mem_size  out  2  0=byte, 1=half, 2=word.
- mem_addr  out  32  request address.
- mem_wstrb  out  4  byte strobes (0000 for reads).
- mem_wdata  out  32  write data.
- mem_addr_ok  in  1  request accepted this cycle.
- mem_data_ok  in  1  response valid this cycle.
- mem_rdata  in  32  response data.

Behaviour:
- States: IDLE, REQ, WAIT, DONE. A one-hot or binary encoding is permitted.
- Reset, and any cycle with rst=1, gives:
  - state=IDLE, all outputs 0, latched request fields 0, watchdog counter 0.
  - rst=1 takes priority over all other inputs.
  - After reset, a stale mem_data_ok arriving in IDLE is ignored.
- cpu_stall = cpu_en & (state != DONE). This is combinational, so stall rises in the same cycle cpu_en rises.
- IDLE:
  - When cpu_en=1, latch addr, wdata and wen; go to REQ.
  - Derive mem_size from wen: 0001/0010/0100/1000 -> 0; 0011/1100 -> 1; 1111 -> 2; 0000 (read) -> 2.
  - mem_addr = latched address unmodified.
- REQ:
  - mem_req=1; mem_wr=|wen; fields driven from latches and stable until accepted.
  - On mem_addr_ok with mem_data_ok also high: capture mem_rdata and go to DONE.
  - On mem_addr_ok alone: go to WAIT and clear the watchdog.
  - When cpu_en=0 (flush) and mem_addr_ok=0: drop the request and go to IDLE. No memory side effect occurs.
- WAIT:
  - mem_req=0.
  - On mem_data_ok: capture mem_rdata into the data register and go to DONE.
  - Otherwise increment the watchdog. When it reaches TIMEOUT_CYCLES (and TIMEOUT_CYCLES != 0): set err, set data register to 0, go to DONE.
  - If cpu_en drops while in WAIT, the access still completes. On completion go directly to IDLE with no cpu_done pulse, because the result is discarded.
- DONE:
  - cpu_done=1, cpu_stall=0, cpu_rdata=captured data, cpu_err=err flag.
  - Held exactly one cycle; next state IDLE; err cleared.
  - If cpu_en is high in the following IDLE cycle, that is a new access (the back-to-back case).
- Latency:
  - Minimum is 2 cycles from cpu_en rise to cpu_done: IDLE -> REQ, with addr_ok and data_ok both in the REQ cycle, then DONE.
  - General case is 2 + (cycles waiting for addr_ok) + (cycles waiting for data_ok).
- Writes: mem_rdata is ignored and cpu_rdata is 0 in DONE.
- Only one outstanding request exists at a time. mem_data_ok outside REQ/WAIT is ignored.
- The watchdog saturates and never wraps.

Test Plan:
- Word read, zero-wait memory: cpu_en=1, wen=0000, addr=0x00000100; addr_ok and data_ok both high in the REQ cycle, rdata=0xDEADBEEF -> mem_req high 1 cycle with size=2 and wr=0; cpu_done and cpu_rdata=0xDEADBEEF 2 cycles after cpu_en; cpu_stall high for exactly 2 cycles.
- Byte write with delayed handshake: wen=0100, addr=0x00000202, wdata=0x00AB0000; addr_ok after 3 cycles, data_ok 2 cycles later -> mem_req held 4 cycles with size=0 and wstrb=0100; cpu_done 7 cycles after cpu_en; cpu_rdata=0.
- Flush before accept: cpu_en drops while in REQ with addr_ok=0 -> next cycle IDLE, mem_req=0, no cpu_done; a later data_ok pulse is ignored.
- Flush after accept: cpu_en drops in WAIT, then data_ok arrives -> returns to IDLE, no cpu_done; a following new read completes normally.
- Timeout with TIMEOUT_CYCLES=4: addr_ok, then no data_ok -> cpu_done with cpu_err=1 and cpu_rdata=0 after 4 WAIT cycles; err clears the next cycle.
- Reset mid-WAIT: assert rst for 1 cycle -> all outputs 0 next cycle, state IDLE; a subsequent data_ok gives no cpu_done.
